tug_playfield: RTL and testbench

TUG_PLAYFIELD -- requirements
Module: tug_playfield

---
 rtl/tug_pkg.sv | 17 +
 rtl/key_conditioner.sv | 67 ++++++
 rtl/tug_playfield.sv | 97 +++++++++
 tb/tb_tug_playfield.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tug_pkg.sv
// Shared types and helpers for the tug-of-war playfield.
// Winner encoding, default light count and centre index.
package tug_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    LEFT  = 2'b01,
    RIGHT = 2'b10
  } winner_e;

  localparam int NUM_LIGHTS_DEF = 9;

  function automatic int centre_idx(input int n);
    return (n - 1) / 2;
  endfunction

endpackage

// File: rtl/key_conditioner.sv
// Raw key -> 2-flop sync -> optional debounce -> one-cycle rise pulse.
// Debounce stage is present only when TUG_DEBOUNCE_EN is defined.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Key,
  output logic Pulse
);

  logic sync1;
  logic sync2;
  logic level;
  logic level_q;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  // Flops reset to 1 so a key held across reset release is not an edge
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= Key;
      sync2 <= sync1;
    end
  end

`ifdef TUG_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          stable;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt    <= '0;
      stable <= 1'b1;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      stable <= sync2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign level = stable;
`else
  assign level = sync2;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      level_q <= 1'b1;
      Pulse   <= 1'b0;
    end else begin
      level_q <= level;
      Pulse   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/tug_playfield.sv
// Tug-of-war playfield: light position, edge win detection, lockout.
// Optional key debounce enabled by defining TUG_DEBOUNCE_EN.
module tug_playfield
  import tug_pkg::*;
#(
  parameter int NUM_LIGHTS      = NUM_LIGHTS_DEF,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  KeyL,
  input  logic                  KeyR,
  output logic [NUM_LIGHTS-1:0] Leds,
  output logic                  L,
  output logic                  R,
  output logic                  Le,
  output logic                  Re,
  output logic [1:0]            Winner,
  output logic                  GameOver
);

  localparam int PW = $clog2(NUM_LIGHTS);
  localparam logic [PW-1:0] CENTRE = PW'(centre_idx(NUM_LIGHTS));
  localparam logic [PW-1:0] LEFTMOST = PW'(NUM_LIGHTS - 1);

  if (NUM_LIGHTS < 3 || (NUM_LIGHTS % 2) == 0) begin : g_bad_param
    $error("NUM_LIGHTS must be odd and at least 3");
  end

  logic          pulse_l;
  logic          pulse_r;
  logic [PW-1:0] pos;
  winner_e       win;
  logic          over;

  key_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_l (
    .Clock(Clock),
    .Reset(Reset),
    .Key  (KeyL),
    .Pulse(pulse_l)
  );

  key_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_r (
    .Clock(Clock),
    .Reset(Reset),
    .Key  (KeyR),
    .Pulse(pulse_r)
  );

  // Simultaneous presses cancel; a finished game ignores both keys
  assign L = pulse_l & ~pulse_r & ~over;
  assign R = pulse_r & ~pulse_l & ~over;

  assign Le = (pos == LEFTMOST);
  assign Re = (pos == '0);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pos  <= CENTRE;
      win  <= NONE;
      over <= 1'b0;
    end else begin
      unique case (1'b1)
        L: begin
          if (Le) begin
            win  <= LEFT;
            over <= 1'b1;
          end else begin
            pos <= pos + 1'b1;
          end
        end
        R: begin
          if (Re) begin
            win  <= RIGHT;
            over <= 1'b1;
          end else begin
            pos <= pos - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    Leds      = '0;
    Leds[pos] = 1'b1;
  end

  assign Winner   = win;
  assign GameOver = over;

endmodule

// File: tb/tb_tug_playfield.sv
// Directed bench for tug_playfield (NUM_LIGHTS=9).
// Per-cycle vector table plus multi-press / reset sequences.
module tb_tug_playfield;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       KeyL = 1'b0;
  logic       KeyR = 1'b0;
  logic [8:0] Leds;
  logic       L;
  logic       R;
  logic       Le;
  logic       Re;
  logic [1:0] Winner;
  logic       GameOver;

  int checks = 0;
  int failures = 0;
  int lc = 0;
  int rc = 0;

  typedef struct {
    logic       rst;
    logic       kl;
    logic       kr;
    logic [8:0] leds;
    logic       l;
    logic       r;
    logic [1:0] win;
    logic       go;
  } vec_t;

  vec_t vecs[$];

  tug_playfield #(
    .NUM_LIGHTS     (9),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .KeyL    (KeyL),
    .KeyR    (KeyR),
    .Leds    (Leds),
    .L       (L),
    .R       (R),
    .Le      (Le),
    .Re      (Re),
    .Winner  (Winner),
    .GameOver(GameOver)
  );

  always #5 Clock = ~Clock;

  task automatic add(input logic rst, input logic kl, input logic kr,
                     input logic [8:0] leds, input logic l,
                     input logic r, input logic [1:0] win,
                     input logic go, input int n);
    vec_t v;
    v.rst = rst; v.kl = kl; v.kr = kr; v.leds = leds;
    v.l = l; v.r = r; v.win = win; v.go = go;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
    if (L === 1'b1) lc++;
    if (R === 1'b1) rc++;
  endtask

  task automatic press(input bit left);
    lc = 0;
    rc = 0;
    if (left) KeyL = 1'b1; else KeyR = 1'b1;
    repeat (5) cyc();
    KeyL = 1'b0;
    KeyR = 1'b0;
    repeat (2) cyc();
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    repeat (2) cyc();
    Reset = 1'b1;
    cyc();
  endtask

  initial begin
`ifdef TUG_DEBOUNCE_EN
    do_reset();
    rc = 0;
    foreach (vecs[i]) ;
    KeyR = 1'b1; cyc();
    KeyR = 1'b0; cyc();
    KeyR = 1'b1; cyc();
    KeyR = 1'b0;
    repeat (10) cyc();
    chk("db_glitch_r", rc, 0);
    chk("db_glitch_leds", Leds, 9'h010);
    rc = 0;
    KeyR = 1'b1;
    repeat (6) cyc();
    KeyR = 1'b0;
    repeat (10) cyc();
    chk("db_hold_r", rc, 1);
    chk("db_hold_leds", Leds, 9'h008);
`else
    // rst kl kr leds L R win go count
    add(0, 0, 0, 9'h010, 0, 0, 2'd0, 0, 1);
    add(1, 0, 0, 9'h010, 0, 0, 2'd0, 0, 1);
    add(1, 1, 0, 9'h010, 0, 0, 2'd0, 0, 2);
    add(1, 1, 0, 9'h010, 1, 0, 2'd0, 0, 1);
    add(1, 1, 0, 9'h020, 0, 0, 2'd0, 0, 7);
    add(1, 0, 0, 9'h020, 0, 0, 2'd0, 0, 2);
    add(1, 1, 1, 9'h020, 0, 0, 2'd0, 0, 5);
    add(1, 0, 0, 9'h020, 0, 0, 2'd0, 0, 2);
    add(1, 0, 1, 9'h020, 0, 0, 2'd0, 0, 2);
    add(1, 0, 1, 9'h020, 0, 1, 2'd0, 0, 1);
    add(1, 0, 1, 9'h010, 0, 0, 2'd0, 0, 1);
    add(1, 0, 0, 9'h010, 0, 0, 2'd0, 0, 2);

    #1;
    foreach (vecs[i]) begin
      logic [14:0] got;
      logic [14:0] exp;
      Reset = vecs[i].rst;
      KeyL = vecs[i].kl;
      KeyR = vecs[i].kr;
      cyc();
      got = {Leds, L, R, Le, Re, Winner, GameOver};
      exp = {vecs[i].leds, vecs[i].l, vecs[i].r,
             vecs[i].leds[8], vecs[i].leds[0],
             vecs[i].win, vecs[i].go};
      chk($sformatf("vec%0d", i), 32'(got), 32'(exp));
    end

    do_reset();
    for (int i = 1; i <= 4; i++) begin
      press(1'b1);
      chk($sformatf("left%0d_pulses", i), lc, 1);
      chk($sformatf("left%0d_leds", i), Leds, 9'h010 << i);
    end
    chk("left_le", Le, 1);
    chk("left_re", Re, 0);
    press(1'b1);
    chk("left_win_pulse", lc, 1);
    chk("left_win_code", Winner, 2'b01);
    chk("left_win_over", GameOver, 1);
    chk("left_win_leds", Leds, 9'h100);
    press(1'b0);
    chk("over_r_pulse", rc, 0);
    chk("over_r_leds", Leds, 9'h100);
    press(1'b1);
    chk("over_l_pulse", lc, 0);
    chk("over_win_kept", Winner, 2'b01);

    do_reset();
    for (int i = 1; i <= 4; i++) begin
      press(1'b0);
      chk($sformatf("right%0d_leds", i), Leds, 9'h010 >> i);
    end
    chk("right_re", Re, 1);
    chk("right_le", Le, 0);
    press(1'b0);
    chk("right_win_code", Winner, 2'b10);
    chk("right_win_over", GameOver, 1);

    @(negedge Clock);
    Reset = 1'b0;
    #1;
    chk("async_rst_leds", Leds, 9'h010);
    chk("async_rst_over", GameOver, 0);
    chk("async_rst_win", Winner, 2'b00);
    cyc();

    KeyL = 1'b1;
    repeat (3) cyc();
    Reset = 1'b1;
    lc = 0;
    repeat (8) cyc();
    chk("held_rst_pulse", lc, 0);
    chk("held_rst_leds", Leds, 9'h010);
    KeyL = 1'b0;
    repeat (3) cyc();

    do_reset();
    KeyL = 1'b1;
    repeat (2) cyc();
    Reset = 1'b0;
    cyc();
    KeyL = 1'b0;
    Reset = 1'b1;
    lc = 0;
    repeat (6) cyc();
    chk("abort_pulse", lc, 0);
    chk("abort_leds", Leds, 9'h010);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
